// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, instruction} FIFO between the instruction port and decode.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency path from fetch to decode when the queue is empty.
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    fetchValid,
    input  logic [XLEN-1:0]         fetchPc,
    input  logic [31:0]             fetchInstruction,
    output logic                    fetchReady,
    output logic                    decodeValid,
    output logic [XLEN-1:0]         decodePc,
    output logic [31:0]             decodeInstruction,
    output logic                    decodeIsCompact,
    input  logic                    decodeReady,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overflowError
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [XLEN-1:0] r_pcMem    [DEPTH];
    logic [31:0]     r_instrMem [DEPTH];
    logic [AW-1:0]   r_rdPtr;
    logic [AW-1:0]   r_wrPtr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_bypassTake;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && fetchValid && !flush;
`else
    assign w_bypass = 1'b0;
`endif
    // A bypassed word consumed by decode in the same cycle never enters the array.
    assign w_bypassTake = w_bypass && decodeReady;

    assign w_push = fetchValid && !w_full && !flush && !w_bypassTake;
    assign w_pop  = !w_empty && decodeReady && !flush;

    assign fetchReady    = !w_full;
    assign occupancy     = r_count;
    assign overflowError = r_overflow;

    always_comb begin
        decodeValid       = !w_empty;
        decodePc          = w_empty ? '0 : r_pcMem[r_rdPtr];
        decodeInstruction = w_empty ? '0 : r_instrMem[r_rdPtr];
        if (w_bypass) begin
            decodeValid       = 1'b1;
            decodePc          = fetchPc;
            decodeInstruction = fetchInstruction;
        end
        decodeIsCompact = decodeValid && (decodeInstruction != '0) &&
                          (decodeInstruction[1:0] != 2'b11);
    end

    // Payload is never reset or cleared; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pcMem[r_wrPtr]    <= fetchPc;
            r_instrMem[r_wrPtr] <= fetchInstruction;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (flush) begin
                r_rdPtr <= '0;
                r_wrPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
                if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            if (fetchValid && w_full && !flush) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, XLEN=32).
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            fetchValid;
    logic [XLEN-1:0] fetchPc;
    logic [31:0]     fetchInstruction;
    logic            fetchReady;
    logic            decodeValid;
    logic [XLEN-1:0] decodePc;
    logic [31:0]     decodeInstruction;
    logic            decodeIsCompact;
    logic            decodeReady;
    logic [2:0]      occupancy;
    logic            overflowError;

    int unsigned n_vectors     = 0;
    int unsigned n_miscompares = 0;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .fetchValid        (fetchValid),
        .fetchPc           (fetchPc),
        .fetchInstruction  (fetchInstruction),
        .fetchReady        (fetchReady),
        .decodeValid       (decodeValid),
        .decodePc          (decodePc),
        .decodeInstruction (decodeInstruction),
        .decodeIsCompact   (decodeIsCompact),
        .decodeReady       (decodeReady),
        .occupancy         (occupancy),
        .overflowError     (overflowError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        fetchValid       = 1'b1;
        fetchPc          = pc;
        fetchInstruction = instr;
        tick();
        fetchValid = 1'b0;
    endtask

    logic [31:0] model_q[$];
    logic [15:0] ready_pat = 16'b1011_0010_1100_0101;
    int unsigned wrap_k;
    int unsigned wrap_pops;
    logic [31:0] exp_pc;
    logic        model_push;
    logic        model_pop;

    initial begin
        rst = 1'b1; flush = 1'b0; fetchValid = 1'b0; fetchPc = '0;
        fetchInstruction = '0; decodeReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_occ",    occupancy, 0);
        check("rst_fready", fetchReady, 1);
        check("rst_dvalid", decodeValid, 0);
        check("rst_dpc",    decodePc, 0);
        check("rst_dinstr", decodeInstruction, 0);
        check("rst_cmp",    decodeIsCompact, 0);
        check("rst_ovf",    overflowError, 0);
        rst = 1'b0;

        // Fill to DEPTH with decode stalled, then overflow, then drain in order.
        for (int k = 0; k < 4; k++) begin
            push(32'(4 * k), 32'h0000_0013 + 32'(k * 32'h100));
            if (k == 0) begin
                check("fill_lat_valid", decodeValid, 1);
                check("fill_lat_pc", decodePc, 0);
            end
        end
        check("full_occ", occupancy, 4);
        check("full_fready", fetchReady, 0);
        check("full_ovf_pre", overflowError, 0);
        push(32'h10, 32'h0000_0013);
        check("ovf_set", overflowError, 1);
        check("ovf_occ", occupancy, 4);
        decodeReady = 1'b1;
        #1;
        check("full_pop_fready", fetchReady, 0);
        for (int k = 0; k < 4; k++) begin
            check("drain_pc", decodePc, 64'(4 * k));
            check("drain_instr", decodeInstruction, 64'(32'h0000_0013 + 32'(k * 32'h100)));
            tick();
        end
        check("drain_dvalid", decodeValid, 0);
        check("drain_occ", occupancy, 0);
        check("drain_dinstr", decodeInstruction, 0);

        // Wrap-around: 10 pushes against a fixed irregular decodeReady pattern.
        wrap_k = 0;
        wrap_pops = 0;
        model_q.delete();
        for (int c = 0; c < 40; c++) begin
            fetchValid       = (wrap_k < 10);
            fetchPc          = 32'h100 + 32'(4 * wrap_k);
            fetchInstruction = 32'h0000_0013;
            decodeReady      = ready_pat[c % 16];
            #1;
            check("wrap_occ", occupancy, 64'(model_q.size()));
            if (model_q.size() > 0) begin
                exp_pc = model_q[0];
                check("wrap_dvalid", decodeValid, 1);
                check("wrap_head", decodePc, 64'(exp_pc));
            end else if (BYP && fetchValid) begin
                check("wrap_byp_pc", decodePc, 64'(fetchPc));
            end else begin
                check("wrap_empty", decodeValid, 0);
            end
            model_pop  = decodeReady && (model_q.size() > 0 || (BYP && fetchValid));
            model_push = fetchValid && (model_q.size() != 4) &&
                         !(BYP && model_q.size() == 0 && decodeReady);
            if (model_pop) begin
                wrap_pops++;
                if (model_q.size() > 0) void'(model_q.pop_front());
            end
            if (model_push) model_q.push_back(fetchPc);
            if (fetchValid && (model_q.size() <= 4) && (model_push || (BYP && model_pop && !model_push && fetchValid && model_q.size() == 0)))
                wrap_k++;
            tick();
            if (wrap_k >= 10 && model_q.size() == 0) break;
        end
        fetchValid  = 1'b0;
        decodeReady = 1'b0;
        check("wrap_pops", wrap_pops, 10);
        check("wrap_final_occ", occupancy, 0);

        // Flush beats a same-cycle push; overflow flag survives.
        push(32'h500, 32'h13); push(32'h504, 32'h13); push(32'h508, 32'h13);
        check("flush_pre_occ", occupancy, 3);
        flush = 1'b1;
        push(32'h200, 32'h13);
        flush = 1'b0;
        check("flush_occ", occupancy, 0);
        check("flush_dvalid", decodeValid, 0);
        check("flush_ovf_kept", overflowError, 1);
        push(32'h300, 32'h13);
        check("flush_next_valid", decodeValid, 1);
        check("flush_next_pc", decodePc, 64'h300);
        check("flush_next_occ", occupancy, 1);
        decodeReady = 1'b1; tick(); decodeReady = 1'b0;
        check("flush_drain_occ", occupancy, 0);

        // Compact detection.
        push(32'h700, 32'h0000_4501); push(32'h702, 32'h0000_0013); push(32'h706, 32'h0000_0000);
        check("cmp_rvc", decodeIsCompact, 1);
        decodeReady = 1'b1; tick();
        check("cmp_full32", decodeIsCompact, 0);
        tick();
        check("cmp_zero_valid", decodeValid, 1);
        check("cmp_zero", decodeIsCompact, 0);
        tick(); decodeReady = 1'b0;
        check("cmp_drain_occ", occupancy, 0);

        // Empty-queue latency: zero with bypass, one cycle without.
        fetchValid = 1'b1; fetchPc = 32'h40; fetchInstruction = 32'h13; decodeReady = 1'b1;
        #1;
        if (BYP) begin
            check("byp_valid", decodeValid, 1);
            check("byp_pc", decodePc, 64'h40);
            tick();
            fetchValid = 1'b0;
            check("byp_occ", occupancy, 0);
        end else begin
            check("nobyp_valid", decodeValid, 0);
            tick();
            fetchValid = 1'b0;
            #1;
            check("nobyp_valid_next", decodeValid, 1);
            check("nobyp_pc_next", decodePc, 64'h40);
            tick();
            check("nobyp_drain_occ", occupancy, 0);
        end
        decodeReady = 1'b0;

        // Asynchronous reset mid-cycle with entries queued.
        push(32'h800, 32'h13); push(32'h804, 32'h13); push(32'h808, 32'h13);
        #2;
        rst = 1'b1;
        #1;
        check("arst_occ", occupancy, 0);
        check("arst_dvalid", decodeValid, 0);
        check("arst_dinstr", decodeInstruction, 0);
        check("arst_fready", fetchReady, 1);
        check("arst_ovf", overflowError, 0);
        rst = 1'b0;
        push(32'h600, 32'h13);
        check("post_rst_valid", decodeValid, 1);
        check("post_rst_pc", decodePc, 64'h600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue between the MMU instruction port and the IF/ID stage. It replaces the single IF/ID barrier with a DEPTH-entry FIFO of {pc, instruction} pairs, so fetch can run ahead of decode stalls and freezes. It also flags compact (RVC) instructions and discards all queued entries on a branch redirect.

## Interface
- XLEN, 32, width of program counter and entry pc field
- DEPTH, 4, number of queue entries; power of two, >= 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- flush  in  1  branch redirect; empties the queue
- fetchValid  in  1  instruction memory returned a valid word this cycle
- fetchPc  in  XLEN  pc of the fetched word
- fetchInstruction  in  32  fetched word
- fetchReady  out  1  queue accepts a push this cycle
- decodeValid  out  1  head entry valid for decode
- decodePc  out  XLEN  pc of head entry
- decodeInstruction  out  32  head instruction; 32'h00000000 when decodeValid=0
- decodeIsCompact  out  1  head is compact: decodeValid && instr != 0 && instr[1:0] != 2'b11
- decodeReady  in  1  decode consumes head (not stalled, not frozen)
- occupancy  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- overflowError  out  1  sticky; set on push attempt while full

## Operation
- Storage: DEPTH x (XLEN+32) register array, read pointer, write pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register $clog2(DEPTH)+1 bits.
- push = fetchValid && fetchReady && !flush; pop = decodeValid && decodeReady && !flush.
- fetchReady = (count != DEPTH). Combinational from count only; no dependency on decodeReady (full queue with same-cycle pop still reports fetchReady=0).
- Push writes entry at write pointer, write pointer +1. Pop advances read pointer +1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Empty: decodeValid=0, decodePc=0, decodeInstruction=0, decodeIsCompact=0; decodeReady ignored.
- Full: fetchValid=1 sets overflowError (entry dropped, state unchanged otherwise). overflowError clears only on rst.
- Flush: next cycle count=0, read pointer = write pointer = 0; any push or pop in the flush cycle is discarded. Flush has priority over all other events. overflowError unaffected.
- Entry payload not cleared on flush/pop; only pointers/count define validity.

## Timing
- Reset (async assert): count=0, pointers=0, overflowError=0; so fetchReady=1, decodeValid=0, decodePc=0, decodeInstruction=0, decodeIsCompact=0, occupancy=0. Array contents undefined but never visible.
- Push-to-head latency: 1 cycle (entry written at edge N visible on decode outputs after edge N when queue was empty).
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.
- occupancy, fetchReady, decode outputs are functions of registered state only (except bypass, below).
- Deassertion of rst synchronous-safe: first push accepted on first edge with rst low.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0, fetchValid=1, flush=0, fetch inputs drive decode outputs combinationally (decodeValid=1, zero latency). If decodeReady=1 that cycle the word is consumed and not written (count stays 0); otherwise it is written normally.
- Undefined: no bypass; empty queue always yields decodeValid=0, latency exactly 1 cycle.

## Test plan
- Reset mid-traffic: fill 3 entries, assert rst asynchronously between edges -> outputs immediately occupancy=0, decodeValid=0, decodeInstruction=0, fetchReady=1.
- Fill/drain (DEPTH=4, decodeReady=0): push pc 0x00,0x04,0x08,0x0C instr 0x00000013.. -> occupancy=4, fetchReady=0; 5th push sets overflowError=1; then decodeReady=1 -> pcs pop in order 0x00..0x0C, then decodeValid=0.
- Wrap-around: 10 pushes with random decodeReady, pcs 0x100+4k -> pop order strictly 0x100..0x124, no loss, occupancy never exceeds 4.
- Flush: occupancy=3, flush=1 with fetchValid=1 pc 0x200 same cycle -> next cycle occupancy=0, 0x200 not present; next push pc 0x300 appears as head.
- Compact detect: push instr 0x00004501, 0x00000013, 0x00000000 -> decodeIsCompact 1, 0, 0.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty, fetchValid=1 pc 0x40, decodeReady=1 -> decodeValid=1, decodePc=0x40 same cycle, occupancy stays 0; without macro decodePc=0x40 appears one cycle later.
